ahb_lite_arbiter2: RTL and testbench

- Two-master AHB-Lite arbiter/multiplexer sharing one downstream AHB-Lite port.
- Slot S0 is the Cortex-M0 master; slot S1 is the DMA master. The downstream port feeds the system interconnect/decoder.
- AHB-Lite masters have no HGRANT, so a losing master's address phase is captured in a hold register and the master is stalled via its HREADYOUT until its transfer has been issued downstream and completed.

---
 rtl/ahb_arb_pkg.sv | 17 +
 rtl/ahb_arb_slot.sv | 38 +++
 rtl/ahb_lite_arbiter2.sv | 111 +++++++++++
 tb/tb_ahb_lite_arbiter2.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arb_pkg.sv
// ahb_arb_pkg: shared AHB-Lite encodings and address-phase bundle for the two-master arbiter
package ahb_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic {S0 = 1'b0, S1 = 1'b1} mst_t;
  typedef struct packed {
    logic [31:0] addr;
    htrans_t     trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic        lock;
  } aphase_t;
  function automatic logic is_active(htrans_t t);
    return t == NONSEQ || t == SEQ;
  endfunction
endpackage

// File: rtl/ahb_arb_slot.sv
// ahb_arb_slot: per-master hold register, pend flag, stall/error generation and live-vs-hold select
module ahb_arb_slot
  import ahb_arb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  aphase_t live,
  input  logic    issue,
  input  logic    data_mine,
  input  logic    m_hready,
  input  logic    m_hresp,
  output aphase_t sel,
  output logic    req,
  output logic    hreadyout,
  output logic    hresp
);
  aphase_t hold;
  logic    pend;
  logic    accept;
  logic    capture;
  always_comb begin
    hreadyout = pend ? 1'b0 : data_mine ? m_hready : 1'b1;
    accept    = is_active(live.trans) && hreadyout;
    capture   = accept && !issue;
    req       = pend || accept;
    sel       = pend ? hold : live;
    hresp     = data_mine && m_hresp;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      hold <= '0;
    end else begin
      pend <= capture || (pend && !issue);
      if (capture) hold <= live;
    end
  end
endmodule

// File: rtl/ahb_lite_arbiter2.sv
// ahb_lite_arbiter2: two-master AHB-Lite arbiter sharing one downstream port
module ahb_lite_arbiter2
  import ahb_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] S0_HADDR,
  input  logic [1:0]  S0_HTRANS,
  input  logic        S0_HWRITE,
  input  logic [2:0]  S0_HSIZE,
  input  logic [2:0]  S0_HBURST,
  input  logic [3:0]  S0_HPROT,
  input  logic        S0_HMASTLOCK,
  input  logic [31:0] S0_HWDATA,
  output logic [31:0] S0_HRDATA,
  output logic        S0_HREADYOUT,
  output logic        S0_HRESP,
  input  logic [31:0] S1_HADDR,
  input  logic [1:0]  S1_HTRANS,
  input  logic        S1_HWRITE,
  input  logic [2:0]  S1_HSIZE,
  input  logic [2:0]  S1_HBURST,
  input  logic [3:0]  S1_HPROT,
  input  logic        S1_HMASTLOCK,
  input  logic [31:0] S1_HWDATA,
  output logic [31:0] S1_HRDATA,
  output logic        S1_HREADYOUT,
  output logic        S1_HRESP,
  output logic [31:0] M_HADDR,
  output logic [1:0]  M_HTRANS,
  output logic        M_HWRITE,
  output logic [2:0]  M_HSIZE,
  output logic [2:0]  M_HBURST,
  output logic [3:0]  M_HPROT,
  output logic        M_HMASTLOCK,
  output logic [31:0] M_HWDATA,
  input  logic [31:0] M_HRDATA,
  input  logic        M_HREADY,
  input  logic        M_HRESP,
  output logic        M_HMASTER
);
  aphase_t    live [2];
  aphase_t    sel  [2];
  aphase_t    m;
  logic [1:0] req, rdy, rsp, issue, data_mine;
  mst_t       owner_q, last_grant, data_owner, rr_pick, arb, grant;
  logic       data_valid, retain;
  htrans_t    out_trans;
  assign live[0] = '{addr: S0_HADDR, trans: htrans_t'(S0_HTRANS), write: S0_HWRITE, size: S0_HSIZE,
                     burst: S0_HBURST, prot: S0_HPROT, lock: S0_HMASTLOCK};
  assign live[1] = '{addr: S1_HADDR, trans: htrans_t'(S1_HTRANS), write: S1_HWRITE, size: S1_HSIZE,
                     burst: S1_HBURST, prot: S1_HPROT, lock: S1_HMASTLOCK};
  for (genvar g = 0; g < 2; g++) begin : g_slot
    ahb_arb_slot u_slot (
      .clk       (HCLK),
      .rst       (HRESET),
      .live      (live[g]),
      .issue     (issue[g]),
      .data_mine (data_mine[g]),
      .m_hready  (M_HREADY),
      .m_hresp   (M_HRESP),
      .sel       (sel[g]),
      .req       (req[g]),
      .hreadyout (rdy[g]),
      .hresp     (rsp[g])
    );
  end
  // Owner is frozen during wait states so the downstream address phase stays stable
  always_comb begin
    retain    = sel[owner_q].trans == SEQ || sel[owner_q].trans == BUSY || sel[owner_q].lock;
    rr_pick   = ROUND_ROBIN ? mst_t'(~last_grant) : S0;
    arb       = retain ? owner_q : (req[0] && req[1]) ? rr_pick : req[0] ? S0 : req[1] ? S1 : owner_q;
    grant     = M_HREADY ? arb : owner_q;
    m         = sel[grant];
    out_trans = (req[grant] || m.trans == BUSY) ? m.trans : IDLE;
    issue     = {2{M_HREADY && is_active(out_trans)}} & {grant == S1, grant == S0};
    data_mine = {2{data_valid}} & {data_owner == S1, data_owner == S0};
  end
  assign M_HADDR      = m.addr;
  assign M_HTRANS     = out_trans;
  assign M_HWRITE     = m.write;
  assign M_HSIZE      = m.size;
  assign M_HBURST     = m.burst;
  assign M_HPROT      = m.prot;
  assign M_HMASTLOCK  = m.lock;
  assign M_HMASTER    = grant;
  assign M_HWDATA     = data_owner == S1 ? S1_HWDATA : S0_HWDATA;
  assign S0_HRDATA    = M_HRDATA;
  assign S1_HRDATA    = M_HRDATA;
  assign S0_HREADYOUT = rdy[0];
  assign S1_HREADYOUT = rdy[1];
  assign S0_HRESP     = rsp[0];
  assign S1_HRESP     = rsp[1];
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      owner_q    <= S0;
      last_grant <= S1;
      data_owner <= S0;
      data_valid <= 1'b0;
    end else if (M_HREADY) begin
      owner_q    <= grant;
      data_valid <= is_active(out_trans);
      if (is_active(out_trans)) begin
        data_owner <= grant;
        last_grant <= grant;
      end
    end
  end
endmodule

// File: tb/tb_ahb_lite_arbiter2.sv
// tb_ahb_lite_arbiter2: directed scenarios plus randomized traffic checked against a transfer scoreboard
module tb_ahb_lite_arbiter2;
  localparam logic [1:0] T_IDLE = 2'b00, T_NS = 2'b10, T_SEQ = 2'b11;
  typedef struct packed {logic [31:0] a; logic w;} xf_t;
  logic        HCLK = 1'b0, HRESET = 1'b1;
  logic [31:0] S0_HADDR, S1_HADDR, S0_HWDATA, S1_HWDATA, S0_HRDATA, S1_HRDATA;
  logic [1:0]  S0_HTRANS, S1_HTRANS;
  logic        S0_HWRITE, S1_HWRITE, S0_HMASTLOCK, S1_HMASTLOCK;
  logic [2:0]  S0_HSIZE, S1_HSIZE, S0_HBURST, S1_HBURST;
  logic [3:0]  S0_HPROT, S1_HPROT;
  logic        S0_HREADYOUT, S1_HREADYOUT, S0_HRESP, S1_HRESP;
  logic [31:0] M_HADDR, M_HWDATA, M_HRDATA;
  logic [1:0]  M_HTRANS;
  logic        M_HWRITE, M_HMASTLOCK, M_HREADY, M_HRESP, M_HMASTER;
  logic [2:0]  M_HSIZE, M_HBURST;
  logic [3:0]  M_HPROT;
  int checks = 0, errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_arbiter2 dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .S0_HADDR(S0_HADDR), .S0_HTRANS(S0_HTRANS), .S0_HWRITE(S0_HWRITE), .S0_HSIZE(S0_HSIZE),
    .S0_HBURST(S0_HBURST), .S0_HPROT(S0_HPROT), .S0_HMASTLOCK(S0_HMASTLOCK), .S0_HWDATA(S0_HWDATA),
    .S0_HRDATA(S0_HRDATA), .S0_HREADYOUT(S0_HREADYOUT), .S0_HRESP(S0_HRESP),
    .S1_HADDR(S1_HADDR), .S1_HTRANS(S1_HTRANS), .S1_HWRITE(S1_HWRITE), .S1_HSIZE(S1_HSIZE),
    .S1_HBURST(S1_HBURST), .S1_HPROT(S1_HPROT), .S1_HMASTLOCK(S1_HMASTLOCK), .S1_HWDATA(S1_HWDATA),
    .S1_HRDATA(S1_HRDATA), .S1_HREADYOUT(S1_HREADYOUT), .S1_HRESP(S1_HRESP),
    .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HSIZE(M_HSIZE),
    .M_HBURST(M_HBURST), .M_HPROT(M_HPROT), .M_HMASTLOCK(M_HMASTLOCK), .M_HWDATA(M_HWDATA),
    .M_HRDATA(M_HRDATA), .M_HREADY(M_HREADY), .M_HRESP(M_HRESP), .M_HMASTER(M_HMASTER)
  );

  task automatic set_m(input int mi, input logic [1:0] t, input logic [31:0] a, input logic w,
                       input logic [2:0] b, input logic l);
    if (mi == 0) begin
      S0_HTRANS = t; S0_HADDR = a; S0_HWRITE = w; S0_HBURST = b; S0_HMASTLOCK = l;
    end else begin
      S1_HTRANS = t; S1_HADDR = a; S1_HWRITE = w; S1_HBURST = b; S1_HMASTLOCK = l;
    end
  endtask

  task automatic cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset;
    cyc;
    HRESET = 1'b1; M_HREADY = 1'b1; M_HRESP = 1'b0;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    set_m(1, T_IDLE, 0, 0, 0, 0);
    cyc;
    HRESET = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    @(negedge HCLK);
    checks++; if (M_HTRANS !== T_IDLE) begin errors++; $display("FAIL reset_htrans: got %b want %b", M_HTRANS, T_IDLE); end
    checks++; if (M_HMASTER !== 1'b0) begin errors++; $display("FAIL reset_hmaster: got %b want 0", M_HMASTER); end
    checks++; if ({S1_HREADYOUT, S0_HREADYOUT} !== 2'b11) begin errors++; $display("FAIL reset_hreadyout: got %b want 11", {S1_HREADYOUT, S0_HREADYOUT}); end
    checks++; if ({S1_HRESP, S0_HRESP} !== 2'b00) begin errors++; $display("FAIL reset_hresp: got %b want 00", {S1_HRESP, S0_HRESP}); end
  endtask

  task automatic test_single;
    do_reset;
    set_m(0, T_NS, 32'h2000_0000, 0, 0, 0);
    @(negedge HCLK);
    checks++; if (M_HADDR !== 32'h2000_0000 || M_HTRANS !== T_NS) begin errors++; $display("FAIL single_addr: got %h/%b want 20000000/10", M_HADDR, M_HTRANS); end
    checks++; if (M_HMASTER !== 1'b0 || S0_HREADYOUT !== 1'b1) begin errors++; $display("FAIL single_own: got mst=%b rdy=%b want 0/1", M_HMASTER, S0_HREADYOUT); end
    cyc;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    M_HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    checks++; if (S0_HRDATA !== 32'hDEAD_BEEF || S0_HREADYOUT !== 1'b1) begin errors++; $display("FAIL single_rdata: got %h rdy=%b want deadbeef/1", S0_HRDATA, S0_HREADYOUT); end
  endtask

  task automatic test_contention;
    do_reset;
    set_m(0, T_NS, 32'h4000_0000, 1, 0, 0);
    set_m(1, T_NS, 32'h2000_0100, 0, 0, 0);
    S0_HWDATA = 32'h1111_1111;
    @(negedge HCLK);
    checks++; if (M_HMASTER !== 1'b0 || M_HADDR !== 32'h4000_0000 || M_HWRITE !== 1'b1) begin errors++; $display("FAIL cont_first: got mst=%b addr=%h w=%b want 0/40000000/1", M_HMASTER, M_HADDR, M_HWRITE); end
    checks++; if (S1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL cont_accept: got %b want 1", S1_HREADYOUT); end
    cyc;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    set_m(1, T_IDLE, 0, 0, 0, 0);
    @(negedge HCLK);
    checks++; if (S1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL cont_stall: got %b want 0", S1_HREADYOUT); end
    checks++; if (M_HMASTER !== 1'b1 || M_HADDR !== 32'h2000_0100 || M_HTRANS !== T_NS || M_HWRITE !== 1'b0) begin errors++; $display("FAIL cont_second: got mst=%b addr=%h tr=%b want 1/20000100/10", M_HMASTER, M_HADDR, M_HTRANS); end
    checks++; if (M_HWDATA !== 32'h1111_1111) begin errors++; $display("FAIL cont_wdata: got %h want 11111111", M_HWDATA); end
    cyc;
    @(negedge HCLK);
    checks++; if (S1_HREADYOUT !== 1'b1 || M_HTRANS !== T_IDLE) begin errors++; $display("FAIL cont_done: got rdy=%b tr=%b want 1/00", S1_HREADYOUT, M_HTRANS); end
  endtask

  task automatic test_burst;
    do_reset;
    for (int b = 0; b < 5; b++) begin
      if (b < 4) set_m(1, b == 0 ? T_NS : T_SEQ, 32'h2000_0200 + 4 * b, 0, 3'b011, 0);
      else set_m(1, T_IDLE, 0, 0, 0, 0);
      if (b == 1) set_m(0, T_NS, 32'h3000_0000, 0, 0, 0);
      if (b == 2) set_m(0, T_IDLE, 0, 0, 0, 0);
      @(negedge HCLK);
      if (b < 4) begin
        checks++; if (M_HMASTER !== 1'b1 || M_HADDR !== 32'h2000_0200 + 4 * b) begin errors++; $display("FAIL burst_beat%0d: got mst=%b addr=%h want 1/%h", b, M_HMASTER, M_HADDR, 32'h2000_0200 + 4 * b); end
      end else begin
        checks++; if (M_HMASTER !== 1'b0 || M_HADDR !== 32'h3000_0000 || M_HTRANS !== T_NS) begin errors++; $display("FAIL burst_after: got mst=%b addr=%h tr=%b want 0/30000000/10", M_HMASTER, M_HADDR, M_HTRANS); end
      end
      if (b == 2) begin
        checks++; if (S0_HREADYOUT !== 1'b0) begin errors++; $display("FAIL burst_s0stall: got %b want 0", S0_HREADYOUT); end
      end
      cyc;
    end
    set_m(0, T_IDLE, 0, 0, 0, 0);
  endtask

  task automatic test_lock;
    do_reset;
    set_m(0, T_NS, 32'h0000_0100, 1, 0, 1);
    @(negedge HCLK);
    checks++; if (M_HMASTER !== 1'b0 || M_HMASTLOCK !== 1'b1) begin errors++; $display("FAIL lock_first: got mst=%b lock=%b want 0/1", M_HMASTER, M_HMASTLOCK); end
    cyc;
    set_m(0, T_NS, 32'h0000_0104, 1, 0, 1);
    set_m(1, T_NS, 32'h2000_0300, 0, 0, 0);
    @(negedge HCLK);
    checks++; if (M_HMASTER !== 1'b0 || M_HADDR !== 32'h0000_0104) begin errors++; $display("FAIL lock_second: got mst=%b addr=%h want 0/00000104", M_HMASTER, M_HADDR); end
    cyc;
    set_m(0, T_IDLE, 0, 0, 0, 1);
    set_m(1, T_IDLE, 0, 0, 0, 0);
    @(negedge HCLK);
    checks++; if (M_HMASTER !== 1'b0 || M_HTRANS !== T_IDLE || S1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL lock_hold: got mst=%b tr=%b rdy1=%b want 0/00/0", M_HMASTER, M_HTRANS, S1_HREADYOUT); end
    cyc;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    @(negedge HCLK);
    checks++; if (M_HMASTER !== 1'b1 || M_HADDR !== 32'h2000_0300 || M_HTRANS !== T_NS) begin errors++; $display("FAIL lock_release: got mst=%b addr=%h tr=%b want 1/20000300/10", M_HMASTER, M_HADDR, M_HTRANS); end
    cyc;
  endtask

  task automatic test_error;
    do_reset;
    set_m(1, T_NS, 32'h2000_0400, 0, 0, 0);
    cyc;
    set_m(1, T_IDLE, 0, 0, 0, 0);
    M_HREADY = 1'b0; M_HRESP = 1'b1;
    @(negedge HCLK);
    checks++; if (S1_HRESP !== 1'b1 || S1_HREADYOUT !== 1'b0 || S0_HRESP !== 1'b0) begin errors++; $display("FAIL err_cycle1: got r1=%b rdy1=%b r0=%b want 1/0/0", S1_HRESP, S1_HREADYOUT, S0_HRESP); end
    cyc;
    M_HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if (S1_HRESP !== 1'b1 || S1_HREADYOUT !== 1'b1 || S0_HRESP !== 1'b0) begin errors++; $display("FAIL err_cycle2: got r1=%b rdy1=%b r0=%b want 1/1/0", S1_HRESP, S1_HREADYOUT, S0_HRESP); end
    cyc;
    M_HRESP = 1'b0;
  endtask

  task automatic test_reset_midop;
    do_reset;
    set_m(0, T_NS, 32'h0000_0500, 0, 0, 0);
    cyc;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    set_m(1, T_NS, 32'h2000_0600, 0, 0, 0);
    M_HREADY = 1'b0;
    @(negedge HCLK);
    checks++; if (S0_HREADYOUT !== 1'b0 || S1_HREADYOUT !== 1'b1) begin errors++; $display("FAIL midop_pre: got rdy0=%b rdy1=%b want 0/1", S0_HREADYOUT, S1_HREADYOUT); end
    cyc;
    set_m(1, T_IDLE, 0, 0, 0, 0);
    HRESET = 1'b1;
    @(negedge HCLK);
    checks++; if (S1_HREADYOUT !== 1'b0) begin errors++; $display("FAIL midop_pend: got %b want 0", S1_HREADYOUT); end
    cyc;
    HRESET = 1'b0; M_HREADY = 1'b1;
    @(negedge HCLK);
    checks++; if (M_HTRANS !== T_IDLE || M_HMASTER !== 1'b0 || {S1_HREADYOUT, S0_HREADYOUT} !== 2'b11) begin errors++; $display("FAIL midop_after: got tr=%b mst=%b rdy=%b want 00/0/11", M_HTRANS, M_HMASTER, {S1_HREADYOUT, S0_HREADYOUT}); end
    for (int i = 0; i < 4; i++) begin
      cyc;
      @(negedge HCLK);
      checks++; if (M_HTRANS !== T_IDLE) begin errors++; $display("FAIL midop_dropped%0d: got %b want 00", i, M_HTRANS); end
    end
  endtask

  task automatic test_random;
    xf_t        q0[$], q1[$], x;
    logic [1:0] rdy_prev, rdy;
    logic       dp_v, dp_m, nv, nm;
    int         n0, n1;
    do_reset;
    rdy_prev = 2'b11; dp_v = 1'b0; dp_m = 1'b0;
    for (int c = 0; c < 460; c++) begin
      M_HREADY = $urandom_range(0, 3) != 0;
      M_HRDATA = $urandom;
      if (rdy_prev[0]) begin
        set_m(0, (c < 400 && $urandom_range(0, 1) == 1) ? T_NS : T_IDLE, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 0, 0);
        S0_HWDATA = $urandom;
      end
      if (rdy_prev[1]) begin
        set_m(1, (c < 400 && $urandom_range(0, 1) == 1) ? T_NS : T_IDLE, $urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 0, 0);
        S1_HWDATA = $urandom;
      end
      @(negedge HCLK);
      rdy = {S1_HREADYOUT, S0_HREADYOUT};
      n0 = q0.size(); n1 = q1.size();
      if (n0 == 0 && !(dp_v && dp_m == 1'b0)) begin
        checks++; if (rdy[0] !== 1'b1) begin errors++; $display("FAIL rnd_idle_rdy0 c=%0d: got %b want 1", c, rdy[0]); end
      end
      if (n1 == 0 && !(dp_v && dp_m == 1'b1)) begin
        checks++; if (rdy[1] !== 1'b1) begin errors++; $display("FAIL rnd_idle_rdy1 c=%0d: got %b want 1", c, rdy[1]); end
      end
      if (S0_HTRANS == T_NS && rdy[0]) q0.push_back('{S0_HADDR, S0_HWRITE});
      if (S1_HTRANS == T_NS && rdy[1]) q1.push_back('{S1_HADDR, S1_HWRITE});
      checks++; if (S0_HRDATA !== M_HRDATA || S1_HRDATA !== M_HRDATA) begin errors++; $display("FAIL rnd_rdata c=%0d: got %h/%h want %h", c, S0_HRDATA, S1_HRDATA, M_HRDATA); end
      if (dp_v) begin
        checks++; if (M_HWDATA !== (dp_m ? S1_HWDATA : S0_HWDATA)) begin errors++; $display("FAIL rnd_wdata c=%0d: got %h want %h", c, M_HWDATA, dp_m ? S1_HWDATA : S0_HWDATA); end
        checks++; if ((dp_m ? rdy[1] : rdy[0]) !== M_HREADY) begin errors++; $display("FAIL rnd_dp_rdy c=%0d: got %b want %b", c, dp_m ? rdy[1] : rdy[0], M_HREADY); end
      end
      nv = dp_v; nm = dp_m;
      if (M_HREADY) begin
        nv = 1'b0;
        if (M_HTRANS == T_NS) begin
          nv = 1'b1; nm = M_HMASTER;
          checks++;
          if ((M_HMASTER ? q1.size() : q0.size()) == 0) begin
            errors++; $display("FAIL rnd_spurious c=%0d: got issue from master %b want none", c, M_HMASTER);
          end else begin
            x = M_HMASTER ? q1.pop_front() : q0.pop_front();
            if ({M_HADDR, M_HWRITE} !== x) begin errors++; $display("FAIL rnd_issue c=%0d: got %h/%b want %h/%b", c, M_HADDR, M_HWRITE, x.a, x.w); end
          end
        end else begin
          checks++; if (M_HTRANS !== T_IDLE) begin errors++; $display("FAIL rnd_htrans c=%0d: got %b want 00", c, M_HTRANS); end
        end
      end
      cyc;
      dp_v = nv; dp_m = nm; rdy_prev = rdy;
    end
    checks++; if (q0.size() + q1.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d/%0d outstanding want 0/0", q0.size(), q1.size()); end
    set_m(0, T_IDLE, 0, 0, 0, 0);
    set_m(1, T_IDLE, 0, 0, 0, 0);
  endtask

  initial begin
    S0_HSIZE = 3'b010; S1_HSIZE = 3'b010; S0_HPROT = 4'b0011; S1_HPROT = 4'b0011;
    S0_HWDATA = '0; S1_HWDATA = '0; M_HRDATA = '0; M_HREADY = 1'b1; M_HRESP = 1'b0;
    set_m(0, T_IDLE, 0, 0, 0, 0);
    set_m(1, T_IDLE, 0, 0, 0, 0);
    test_reset;
    test_single;
    test_contention;
    test_burst;
    test_lock;
    test_error;
    test_reset_midop;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
